alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: ACC_RESET, 8'h00, accumulator value loaded on reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  block can accept a command; equals (state==IDLE).
REQ-006 cmd_op  input  3  000 AND, 001 OR, 010 XOR, 011 ADD, 100 LOAD, 101 CLR, 110/111 NOP.
REQ-007 cmd_data  input  8  operand B (LOAD value).
REQ-008 alu_a, alu_b  output  4 each  nibble operands driven to the 4-bit ALU.
REQ-009 alu_sel  output  2  ALU opcode: 00 AND, 01 OR, 10 XOR, 11 ADD.
REQ-010 alu_out  input  4  ALU result nibble (combinational, same cycle).
REQ-011 alu_carry  input  1  ALU carry out (0 for logic ops).
REQ-012 alu_zero  input  1  ALU flag, 1 when alu_out==0.
REQ-013 rsp_valid  output  1  response present.
REQ-014 rsp_ready  input  1  consumer accepts response.
REQ-015 rsp_data  output  8  new accumulator value.
REQ-016 rsp_carry, rsp_zero  output  1 each  8-bit carry out; result==0.

Function
REQ-017 States: IDLE, LO, HI, INC, RSP; one state per cycle except IDLE/RSP, which hold.
REQ-018 Command accepted on an edge with cmd_valid & cmd_ready; cmd_op, cmd_data latched then; no acceptance outside IDLE.
REQ-019 AND/OR/XOR/ADD: IDLE -> LO -> HI -> RSP; ADD with LO carry=1: IDLE -> LO -> HI -> INC -> RSP.
REQ-020 LO: alu_a=acc[3:0], alu_b=data[3:0], alu_sel=op[1:0]; alu_out, alu_carry, alu_zero captured at end of cycle.
REQ-021 HI: alu_a=acc[7:4], alu_b=data[7:4], alu_sel=op[1:0]; results captured.
REQ-022 INC: alu_a=HI result, alu_b=4'h1, alu_sel=11; replaces HI result; final carry = HI carry OR INC carry.
REQ-023 rsp_data={hi nibble, lo nibble}; rsp_carry=final high carry for ADD, 0 for logic ops; rsp_zero=LO alu_zero AND final high-pass alu_zero.
REQ-024 LOAD: IDLE -> RSP; result=cmd_data, carry 0, zero=(cmd_data==0); no ALU pass.
REQ-025 CLR: IDLE -> RSP; result 8'h00, carry 0, zero 1.
REQ-026 NOP: IDLE -> RSP; result=acc unchanged, carry 0, zero=(acc==0).
REQ-027 acc, rsp_data, rsp_carry, rsp_zero updated on the edge entering RSP; rsp_valid=1 from that edge.
REQ-028 Latency acceptance edge to rsp_valid: 1 cycle LOAD/CLR/NOP, 3 cycles logic/ADD without low carry, 4 cycles ADD with low carry.
REQ-029 RSP holds rsp_* stable until an edge with rsp_ready=1, then -> IDLE; rsp_valid deasserts that edge; no command accepted in that same edge.
REQ-030 Outside LO/HI/INC: alu_a=0, alu_b=0, alu_sel=00.
REQ-031 8-bit ADD wraps modulo 256; overflow reported only through rsp_carry.
REQ-032 cmd_valid deasserted or cmd_* changed mid-operation has no effect.

Reset
REQ-033 rst_n low asynchronously forces: state IDLE, acc=ACC_RESET, rsp_valid 0, rsp_data 0, rsp_carry 0, rsp_zero 0, internal captures 0.
REQ-034 Reset mid-operation (LO/HI/INC/RSP) abandons the command; no response produced; cmd_ready=1 while reset held and after release.

Verification
REQ-035 Reset, LOAD 0x3C -> 1 cycle later rsp_valid, rsp_data 0x3C, carry 0, zero 0.
REQ-036 acc 0x3C, ADD 0x0F -> passes LO(C+F), HI(3+0), INC(3+1); rsp_data 0x4B, carry 0, zero 0, latency 4.
REQ-037 acc 0xF8, ADD 0x08 -> LO 0 c1, HI F, INC 0 c1; rsp_data 0x00, carry 1, zero 1.
REQ-038 acc 0xA5, XOR 0xA5 -> alu_sel 10 both passes, rsp_data 0x00, carry 0, zero 1, latency 3.
REQ-039 rsp_ready low 5 cycles after AND 0x0F on acc 0x3C -> rsp_data 0x0C held stable, cmd_ready 0, later command not accepted until handshake.
REQ-040 rst_n low during HI of ADD -> immediate IDLE, acc 0x00, rsp_valid 0, no response after release.

Source files
------------

// File: rtl/alu_seq_if.sv
// Command, response and nibble-ALU signals of alu_seq, bundled for one connection.
// slave is the sequencer side; master is the command source plus the external 4-bit ALU.
interface alu_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;

  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_sel;
  logic [3:0] alu_out;
  logic       alu_carry;
  logic       alu_zero;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_carry;
  logic       rsp_zero;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready, alu_out, alu_carry, alu_zero,
    output cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_carry, rsp_zero
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready, alu_out, alu_carry, alu_zero,
    input  cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_carry, rsp_zero
  );
endinterface

// File: rtl/alu_seq.sv
// 8-bit accumulator ALU sequenced as nibble passes over an external 4-bit ALU.
// Latency 1 (LOAD/CLR/NOP), 3 (logic/ADD), 4 (ADD with low carry); one command in flight, response held until rsp_ready.
module alu_seq #(
  parameter logic [7:0] ACC_RESET = 8'h00
) (
  input logic     clk,
  input logic     rst_n,
  alu_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LO   = 3'd1,
    HI   = 3'd2,
    INC  = 3'd3,
    RSP  = 3'd4
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_LOAD = 3'b100;
  localparam logic [2:0] OP_CLR  = 3'b101;
  localparam logic [1:0] SEL_ADD = 2'b11;

  state_t     state;
  logic [2:0] op_q;
  logic [3:0] data_hi_q;
  logic [7:0] acc;

  logic [3:0] lo_q;
  logic       lo_c;
  logic       lo_z;
  logic       hi_c;

  logic [3:0] alu_a_q;
  logic [3:0] alu_b_q;
  logic [1:0] alu_sel_q;

  logic       rsp_valid_q;
  logic [7:0] rsp_data_q;
  logic       rsp_carry_q;
  logic       rsp_zero_q;

  assign bus.cmd_ready = (state == IDLE);
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_carry = rsp_carry_q;
  assign bus.rsp_zero  = rsp_zero_q;

  // ALU operand registers are loaded on the edge entering each pass so they are valid for the whole cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_q        <= 3'b000;
      data_hi_q   <= 4'h0;
      acc         <= ACC_RESET;
      lo_q        <= 4'h0;
      lo_c        <= 1'b0;
      lo_z        <= 1'b0;
      hi_c        <= 1'b0;
      alu_a_q     <= 4'h0;
      alu_b_q     <= 4'h0;
      alu_sel_q   <= 2'b00;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_carry_q <= 1'b0;
      rsp_zero_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            op_q      <= bus.cmd_op;
            data_hi_q <= bus.cmd_data[7:4];
            if (!bus.cmd_op[2]) begin
              alu_a_q   <= acc[3:0];
              alu_b_q   <= bus.cmd_data[3:0];
              alu_sel_q <= bus.cmd_op[1:0];
              state     <= LO;
            end else begin
              rsp_valid_q <= 1'b1;
              rsp_carry_q <= 1'b0;
              state       <= RSP;
              case (bus.cmd_op)
                OP_LOAD: begin
                  acc        <= bus.cmd_data;
                  rsp_data_q <= bus.cmd_data;
                  rsp_zero_q <= (bus.cmd_data == 8'h00);
                end
                OP_CLR: begin
                  acc        <= 8'h00;
                  rsp_data_q <= 8'h00;
                  rsp_zero_q <= 1'b1;
                end
                default: begin
                  rsp_data_q <= acc;
                  rsp_zero_q <= (acc == 8'h00);
                end
              endcase
            end
          end
        end

        LO: begin
          lo_q    <= bus.alu_out;
          lo_c    <= bus.alu_carry;
          lo_z    <= bus.alu_zero;
          alu_a_q <= acc[7:4];
          alu_b_q <= data_hi_q;
          state   <= HI;
        end

        HI: begin
          hi_c <= bus.alu_carry;
          // A low-nibble carry is folded in by an extra +1 pass on the high nibble.
          if (op_q == OP_ADD && lo_c) begin
            alu_a_q   <= bus.alu_out;
            alu_b_q   <= 4'h1;
            alu_sel_q <= SEL_ADD;
            state     <= INC;
          end else begin
            acc         <= {bus.alu_out, lo_q};
            rsp_data_q  <= {bus.alu_out, lo_q};
            rsp_carry_q <= (op_q == OP_ADD) & bus.alu_carry;
            rsp_zero_q  <= lo_z & bus.alu_zero;
            rsp_valid_q <= 1'b1;
            alu_a_q     <= 4'h0;
            alu_b_q     <= 4'h0;
            alu_sel_q   <= 2'b00;
            state       <= RSP;
          end
        end

        INC: begin
          acc         <= {bus.alu_out, lo_q};
          rsp_data_q  <= {bus.alu_out, lo_q};
          rsp_carry_q <= hi_c | bus.alu_carry;
          rsp_zero_q  <= lo_z & bus.alu_zero;
          rsp_valid_q <= 1'b1;
          alu_a_q     <= 4'h0;
          alu_b_q     <= 4'h0;
          alu_sel_q   <= 2'b00;
          state       <= RSP;
        end

        RSP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomized bench for alu_seq: external 4-bit ALU model plus an 8-bit arithmetic reference of the accumulator.
// Checks results, flags, latency, nibble passes, response hold and reset behaviour.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst_n;

  alu_seq_if bus();

  alu_seq #(.ACC_RESET(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [7:0] acc_m;

  // External 4-bit ALU
  logic [4:0] alu_res;
  always_comb begin
    alu_res = 5'h00;
    case (bus.alu_sel)
      2'b00:   alu_res = {1'b0, bus.alu_a & bus.alu_b};
      2'b01:   alu_res = {1'b0, bus.alu_a | bus.alu_b};
      2'b10:   alu_res = {1'b0, bus.alu_a ^ bus.alu_b};
      default: alu_res = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
    endcase
  end
  assign bus.alu_out   = alu_res[3:0];
  assign bus.alu_carry = alu_res[4];
  assign bus.alu_zero  = (alu_res[3:0] == 4'h0);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Whole-byte reference: result, carry and latency straight from the operation's meaning.
  task automatic ref_model(input logic [2:0] op, input logic [7:0] d,
                           output logic [7:0] r, output logic c, output int lat);
    int a, b, s;
    a = int'(acc_m);
    b = int'(d);
    c = 1'b0;
    lat = 1;
    case (op)
      3'd0: begin r = acc_m & d; lat = 3; end
      3'd1: begin r = acc_m | d; lat = 3; end
      3'd2: begin r = acc_m ^ d; lat = 3; end
      3'd3: begin
        s   = a + b;
        r   = 8'(s % 256);
        c   = (s > 255);
        lat = (((a % 16) + (b % 16)) > 15) ? 4 : 3;
      end
      3'd4: r = d;
      3'd5: r = 8'h00;
      default: r = acc_m;
    endcase
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [7:0] d, input int hold);
    logic [7:0] er;
    logic       ec;
    logic       ez;
    int         elat;
    int         cyc;
    bit         busy;
    ref_model(op, d, er, ec, elat);
    ez = (er == 8'h00);

    @(negedge clk);
    check_eq("idle_ready", bus.cmd_ready, 1);
    check_eq("idle_alu", {bus.alu_a, bus.alu_b, bus.alu_sel}, 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    bus.rsp_ready = 1'b0;

    cyc  = 0;
    busy = 1'b1;
    while (busy) begin
      @(negedge clk);
      cyc++;
      if (!op[2]) begin
        if (cyc == 1)
          check_eq("lo_pass", {bus.alu_a, bus.alu_b, bus.alu_sel}, {acc_m[3:0], d[3:0], op[1:0]});
        else if (cyc == 2)
          check_eq("hi_pass", {bus.alu_a, bus.alu_b, bus.alu_sel}, {acc_m[7:4], d[7:4], op[1:0]});
        else if (cyc == 3 && elat == 4)
          check_eq("inc_pass", {bus.alu_b, bus.alu_sel}, {4'h1, 2'b11});
      end
      // Inputs changing while busy must be ignored.
      bus.cmd_valid = 1'($urandom_range(0, 1));
      bus.cmd_op    = 3'($urandom);
      bus.cmd_data  = 8'($urandom);
      bus.rsp_ready = 1'($urandom_range(0, 1));
      if (bus.rsp_valid || cyc >= 8) busy = 1'b0;
    end
    check_eq("rsp_valid", bus.rsp_valid, 1);
    check_eq("latency", cyc, elat);
    check_eq("rsp_data", bus.rsp_data, er);
    check_eq("rsp_carry", bus.rsp_carry, ec);
    check_eq("rsp_zero", bus.rsp_zero, ez);

    for (int h = 0; h < hold; h++) begin
      bus.rsp_ready = 1'b0;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 3'd4;
      bus.cmd_data  = 8'hEE;
      @(negedge clk);
      check_eq("rsp_hold", {bus.rsp_valid, bus.cmd_ready, bus.rsp_data, bus.rsp_carry, bus.rsp_zero},
               {1'b1, 1'b0, er, ec, ez});
    end

    // A pending command on the handshake edge must not be taken in that edge.
    bus.rsp_ready = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd4;
    bus.cmd_data  = 8'hEE;
    @(negedge clk);
    check_eq("rsp_release", {bus.rsp_valid, bus.cmd_ready}, {1'b0, 1'b1});
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    acc_m = er;
  endtask

  initial begin
    bit seen;
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_data  = 8'h00;
    bus.rsp_ready = 1'b0;
    acc_m         = 8'h00;
    #3;
    check_eq("reset_out", {bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_carry, bus.rsp_zero},
             {1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
    check_eq("reset_alu", {bus.alu_a, bus.alu_b, bus.alu_sel}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_cmd(3'd4, 8'h3C, 0);
    run_cmd(3'd3, 8'h0F, 1);
    run_cmd(3'd4, 8'hF8, 0);
    run_cmd(3'd3, 8'h08, 2);
    run_cmd(3'd4, 8'hA5, 0);
    run_cmd(3'd2, 8'hA5, 0);
    run_cmd(3'd4, 8'h3C, 0);
    run_cmd(3'd0, 8'h0F, 5);
    run_cmd(3'd1, 8'h50, 0);
    run_cmd(3'd6, 8'h12, 1);
    run_cmd(3'd5, 8'h77, 0);
    run_cmd(3'd7, 8'h34, 0);
    run_cmd(3'd4, 8'h5A, 0);

    // Reset asserted while the ADD is in its high pass.
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd3;
    bus.cmd_data  = 8'h11;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check_eq("pre_rst_hi", {bus.alu_a, bus.alu_b}, {acc_m[7:4], 4'h1});
    #1 rst_n = 1'b0;
    #1;
    check_eq("mid_rst", {bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.alu_a, bus.alu_b, bus.alu_sel},
             {1'b1, 1'b0, 8'h00, 10'h000});
    repeat (3) @(negedge clk);
    check_eq("rst_held_ready", bus.cmd_ready, 1);
    rst_n = 1'b1;
    acc_m = 8'h00;
    seen  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen = seen | bus.rsp_valid;
    end
    check_eq("no_rsp_after_rst", seen, 0);
    run_cmd(3'd6, 8'h00, 0);

    for (int i = 0; i < 250; i++)
      run_cmd(3'($urandom_range(0, 7)), 8'($urandom), $urandom_range(0, 3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
